// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Define UART_ARB_TAG_EN to precede every packet with one tag byte TAG_BASE+grant_id.
module uart_tx_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] TAG_BASE = 8'h80,
  localparam int        ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE, TAG, STREAM} state_t;
`else
  typedef enum logic [1:0] {IDLE, STREAM} state_t;
  // The tag base only matters when tags are compiled in.
  logic unused_tag_base;
  assign unused_tag_base = ^TAG_BASE;
`endif

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_grant, last_grant_nxt, grant_nxt;
  logic [7:0]      req_byte [NUM_REQ];

  // First requester with valid set, searching upward from the one after the last grantee.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && vld[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    tx_valid       = 1'b0;
    tx_data        = '0;
    req_ready      = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_nxt = rr_pick(req_valid, last_grant);
`ifdef UART_ARB_TAG_EN
          state_nxt = TAG;
`else
          state_nxt = STREAM;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        tx_valid = 1'b1;
        tx_data  = TAG_BASE + 8'(grant_id);
        if (tx_ready) state_nxt = STREAM;
      end
`endif
      STREAM: begin
        // Pure pass-through; the grant is held across valid gaps until the last byte moves.
        tx_valid            = req_valid[grant_id];
        tx_data             = req_byte[grant_id];
        req_ready[grant_id] = tx_ready;
        if (req_valid[grant_id] && tx_ready && req_last[grant_id]) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vector table, directed packet sequences and a randomized
// run checked against a transaction-level reference model and a per-source packet scoreboard.
module tb_uart_tx_arbiter;
  localparam int         NUM_REQ  = 4;
  localparam logic [7:0] TAG_BASE = 8'h80;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_ON = 1'b1;
  localparam int BPP    = 2;
`else
  localparam bit TAG_ON = 1'b0;
  localparam int BPP    = 1;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid, req_last, req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid, tx_ready, busy;
  logic [1:0]           grant_id;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TAG_BASE(TAG_BASE)) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Source queues, scoreboard copies, and captured output.
  logic [7:0] q_data [NUM_REQ][$];
  bit         q_last [NUM_REQ][$];
  logic [7:0] sb_d   [NUM_REQ][$];
  bit         sb_l   [NUM_REQ][$];
  logic [7:0] got[$];
  int         got_gid[$];
  bit         tv_trace[$];
  bit         pop_mask [NUM_REQ];
  bit         hold [NUM_REQ];
  bit         force_gate [NUM_REQ];
  bit         rand_mode, sb_en, trace_en;
  int         sb_open, sb_tag_src;

  // Reference model: who owns the transmitter, who went last, pending tag byte.
  int m_owner, m_ptr, m_gid;
  bit m_tag;

  typedef struct {
    logic [3:0] v, l;
    logic       rdy;
    logic       etv, eb;
    logic [1:0] eg;
    logic [3:0] err;
    logic [7:0] etd;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] b, input bit l);
    q_data[s].push_back(b); q_last[s].push_back(l);
    sb_d[s].push_back(b);   sb_l[s].push_back(l);
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = NUM_REQ - 1; m_gid = 0; m_tag = 1'b0;
    sb_open = -1; sb_tag_src = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      q_data[i].delete(); q_last[i].delete(); sb_d[i].delete(); sb_l[i].delete();
      pop_mask[i] = 1'b0; hold[i] = 1'b0; force_gate[i] = 1'b1;
    end
    got.delete(); got_gid.delete(); tv_trace.delete();
  endtask

  task automatic sb_take(input logic [7:0] b);
    int s;
    bit l;
    if (TAG_ON && b >= TAG_BASE) begin
      check("sb_tag_at_boundary", 32'(sb_open == -1), 1);
      sb_tag_src = int'(b - TAG_BASE);
      return;
    end
    s = int'(b[6:5]);
`ifdef UART_ARB_TAG_EN
    if (sb_open == -1) check("sb_tag_src", s, sb_tag_src);
`endif
    if (sb_open != -1) check("sb_interleave", s, sb_open);
    if (sb_d[s].size() == 0) begin
      check("sb_extra_byte", b, 32'hFFFF_FFFF);
    end else begin
      check("sb_byte", b, sb_d[s][0]);
      l = sb_l[s][0];
      void'(sb_d[s].pop_front()); void'(sb_l[s].pop_front());
      sb_open = l ? -1 : s;
    end
  endtask

  task automatic model_check();
    bit         etv, eb;
    logic [3:0] err;
    logic [7:0] etd;
    int         o;
    o = m_owner; eb = (o >= 0); etv = 1'b0; err = '0; etd = '0;
    if (o >= 0 && m_tag) begin
      etv = 1'b1; etd = TAG_BASE + 8'(o);
    end else if (o >= 0) begin
      etv = req_valid[o]; etd = req_data[8*o +: 8]; err[o] = tx_ready;
    end
    check("model_ctl", {tx_valid, busy, grant_id, req_ready}, {etv, eb, 2'(m_gid), err});
    if (etv) check("model_data", tx_data, etd);
    if (tx_valid && tx_ready) begin
      got.push_back(tx_data); got_gid.push_back(int'(grant_id));
      if (sb_en) sb_take(tx_data);
    end
    if (trace_en) tv_trace.push_back(tx_valid);
    for (int i = 0; i < NUM_REQ; i++) begin
      pop_mask[i] = req_valid[i] && req_ready[i];
      hold[i]     = req_valid[i] && !req_ready[i];
    end
    if (o < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (req_valid[(m_ptr + k) % NUM_REQ]) begin
          m_owner = (m_ptr + k) % NUM_REQ; m_gid = m_owner; m_tag = TAG_ON;
          break;
        end
      end
    end else if (m_tag) begin
      if (tx_ready) m_tag = 1'b0;
    end else if (req_valid[o] && tx_ready && req_last[o]) begin
      m_ptr = o; m_owner = -1;
    end
  endtask

  task automatic drive();
    bit g;
    for (int i = 0; i < NUM_REQ; i++) begin
      g = rand_mode ? (hold[i] || ($urandom_range(0, 9) < 7)) : force_gate[i];
      if (g && q_data[i].size() > 0) begin
        req_valid[i] = 1'b1; req_data[8*i +: 8] = q_data[i][0]; req_last[i] = q_last[i][0];
      end else begin
        req_valid[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
      end
    end
    tx_ready = rand_mode ? ($urandom_range(0, 9) < 6) : 1'b1;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pop_mask[i]) begin
        void'(q_data[i].pop_front()); void'(q_last[i].pop_front());
      end
    end
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      step(); c++;
    end
    check({name, "_progress"}, got.size() >= n, 1);
  endtask

  task automatic check_stream(input string name, input logic [7:0] exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", name, i), got[i], exp[i]);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("reset_vals", {tx_valid, busy, grant_id, req_ready, tx_data}, 16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp[$];
    int         c, run, runs, seen_one, left;
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    rand_mode = 1'b0; sb_en = 1'b0; trace_en = 1'b0;
    apply_reset();

    // No requests: everything stays quiet.
    repeat (100) step();

    // Cycle vector table.
`ifdef UART_ARB_TAG_EN
    tbl[0]  = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00};
    tbl[1]  = '{4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00};
    tbl[2]  = '{4'h5, 4'h5, 1'b0, 1'b1, 1'b1, 2'd0, 4'h0, 8'h80};
    tbl[3]  = '{4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 2'd0, 4'h0, 8'h80};
    tbl[4]  = '{4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1, 8'h11};
    tbl[5]  = '{4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00};
    tbl[6]  = '{4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 2'd2, 4'h0, 8'h82};
    tbl[7]  = '{4'h5, 4'h5, 1'b0, 1'b1, 1'b1, 2'd2, 4'h0, 8'h33};
    tbl[8]  = '{4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 2'd2, 4'h4, 8'h33};
    tbl[9]  = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 8'h00};
    tbl[10] = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 8'h00};
`else
    tbl[0]  = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00};
    tbl[1]  = '{4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00};
    tbl[2]  = '{4'h5, 4'h5, 1'b0, 1'b1, 1'b1, 2'd0, 4'h0, 8'h11};
    tbl[3]  = '{4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1, 8'h11};
    tbl[4]  = '{4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00};
    tbl[5]  = '{4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 2'd2, 4'h4, 8'h33};
    tbl[6]  = '{4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 8'h00};
    tbl[7]  = '{4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 4'h1, 8'h00};
    tbl[8]  = '{4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1, 8'h11};
    tbl[9]  = '{4'h5, 4'h1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1, 8'h11};
    tbl[10] = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00};
`endif
    apply_reset();
    req_data = 32'h4433_2211;
    for (int r = 0; r < 11; r++) begin
      req_valid = tbl[r].v; req_last = tbl[r].l; tx_ready = tbl[r].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d_ctl", r), {tx_valid, busy, grant_id, req_ready},
            {tbl[r].etv, tbl[r].eb, tbl[r].eg, tbl[r].err});
      if (tbl[r].etv) check($sformatf("tbl%0d_data", r), tx_data, tbl[r].etd);
      @(posedge clk);
      #1;
    end

    // Requesters 0 and 2 each have a 3-byte packet pending at reset release.
    apply_reset();
    push_byte(0, 8'h11, 0); push_byte(0, 8'h12, 0); push_byte(0, 8'h13, 1);
    push_byte(2, 8'h31, 0); push_byte(2, 8'h32, 0); push_byte(2, 8'h33, 1);
`ifdef UART_ARB_TAG_EN
    exp = {8'h80, 8'h11, 8'h12, 8'h13, 8'h82, 8'h31, 8'h32, 8'h33};
`else
    exp = {8'h11, 8'h12, 8'h13, 8'h31, 8'h32, 8'h33};
`endif
    run_until(exp.size(), 100, "two_pkt");
    check_stream("two_pkt", exp);

    // Fairness: every requester keeps offering single-byte packets.
    apply_reset();
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < NUM_REQ; s++) push_byte(s, 8'(16 * s + p), 1);
    trace_en = 1'b1;
    run_until(12 * BPP, 200, "fair");
    trace_en = 1'b0;
    check("fair_count", got_gid.size(), 12 * BPP);
    for (int t = 0; t < got_gid.size(); t++)
      check($sformatf("fair_gid%0d", t), got_gid[t], (t / BPP) % NUM_REQ);
    run = 0; runs = 0; seen_one = 0;
    foreach (tv_trace[i]) begin
      if (tv_trace[i]) begin
        if (seen_one && run > 0) begin
          check("fair_gap", run, 1); runs++;
        end
        seen_one = 1; run = 0;
      end else if (seen_one) begin
        run++;
      end
    end
    check("fair_gap_count", runs, 11);

    // Valid gap mid-packet while requester 1 waits.
    apply_reset();
    push_byte(0, 8'hA0, 0); push_byte(0, 8'hA1, 1);
    push_byte(1, 8'h2B, 1);
    run_until(BPP, 50, "gap_first");
    force_gate[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("gap_busy", busy, 1);
      check("gap_rr1", req_ready[1], 0);
      check("gap_tv", tx_valid, 0);
    end
    force_gate[0] = 1'b1;
`ifdef UART_ARB_TAG_EN
    exp = {8'h80, 8'hA0, 8'hA1, 8'h81, 8'h2B};
`else
    exp = {8'hA0, 8'hA1, 8'h2B};
`endif
    run_until(exp.size(), 100, "gap");
    check_stream("gap", exp);

    // Reset in the middle of requester 1's packet, after requester 0 went last.
    apply_reset();
    push_byte(0, 8'h05, 1);
    push_byte(1, 8'h61, 0); push_byte(1, 8'h62, 0); push_byte(1, 8'h63, 0); push_byte(1, 8'h64, 1);
    run_until(3 + 2 * (BPP - 1), 100, "midrst_pre");
    check("midrst_busy_before", busy, 1);
    apply_reset();
    push_byte(0, 8'h51, 0); push_byte(0, 8'h52, 1);
    push_byte(1, 8'h71, 1);
`ifdef UART_ARB_TAG_EN
    exp = {8'h80, 8'h51, 8'h52, 8'h81, 8'h71};
`else
    exp = {8'h51, 8'h52, 8'h71};
`endif
    run_until(exp.size(), 100, "midrst");
    check_stream("midrst", exp);

    // Randomized packets, valid gaps and back-pressure against the model and scoreboard.
    apply_reset();
    for (int s = 0; s < NUM_REQ; s++)
      for (int p = 0; p < 6; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++)
          push_byte(s, {1'b0, 2'(s), 5'($urandom)}, b == len - 1);
      end
    rand_mode = 1'b1; sb_en = 1'b1;
    c = 0;
    left = 1;
    while (left != 0 && c < 6000) begin
      step(); c++;
      left = (m_owner >= 0) ? 1 : 0;
      for (int s = 0; s < NUM_REQ; s++) left += q_data[s].size();
    end
    rand_mode = 1'b0; sb_en = 1'b0;
    check("rand_drained", left, 0);
    left = 0;
    for (int s = 0; s < NUM_REQ; s++) left += sb_d[s].size();
    check("rand_sb_empty", left, 0);
    check("rand_sb_closed", sb_open, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
